// File: rtl/axi_lite_mul_engine_if.sv
// AXI4-Lite slave bus bundle for axi_lite_mul_engine.
// Valid/ready rule: a beat transfers on a rising clock edge where both VALID and READY are high.
interface axi_lite_mul_engine_if;
  logic [4:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [4:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi_lite_mul_engine.sv
// AXI4-Lite iterative shift-add multiplier with start/status registers and done interrupt.
// Define HW_MUL_INTR_EN to implement INTR_EN/INTR_STS and drive irq; otherwise irq is 0.
module axi_lite_mul_engine #(
  parameter int OP_W               = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  axi_lite_mul_engine_if.slave   s_axi,
  output logic                   irq,
  output logic [1:0]             dbg_state
);
  localparam int PW    = 2 * OP_W;
  localparam int CNT_W = $clog2(OP_W + 1);
  localparam int STB_W = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, FIN = 2'd3} state_t;

  state_t            state_q, state_d;
  logic              awready_q, awready_d, bvalid_q, bvalid_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              signed_q, signed_d, done_q, done_d, neg_q, neg_d;
  logic [OP_W-1:0]   opa_q, opa_d, opb_q, opb_d, mplier_q, mplier_d;
  logic [PW-1:0]     res_q, res_d, mcand_q, mcand_d, acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              intr_en_q, intr_en_d, intr_sts_q, intr_sts_d, irq_q, irq_d;

  logic              wr_fire, rd_fire, busy, start, a_neg, b_neg;
  logic [2:0]        wr_idx, rd_idx;
  logic [31:0]       rd_val, opa_wr, opb_wr;
  logic [OP_W-1:0]   mag_a, mag_b;
  logic [63:0]       res_ext;
  logic              unused_ok;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] data,
                                        input logic [STB_W-1:0] strb);
    logic [31:0] r;
    for (int i = 0; i < STB_W; i++) r[i*8 +: 8] = strb[i] ? data[i*8 +: 8] : old_v[i*8 +: 8];
    return r;
  endfunction

  assign wr_fire = awready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  assign rd_fire = arready_q & s_axi.S_AXI_ARVALID;
  assign wr_idx  = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_idx  = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign busy    = (state_q != IDLE);
  assign res_ext = 64'(res_q);

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = awready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign irq                 = irq_q;
  assign dbg_state           = state_q;
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  always_comb begin
    rd_val = '0;
    case (rd_idx)
      3'd0: rd_val = {30'b0, signed_q, 1'b0};
      3'd1: rd_val = {30'b0, done_q, busy};
      3'd2: rd_val = 32'(opa_q);
      3'd3: rd_val = 32'(opb_q);
      3'd4: rd_val = res_ext[31:0];
      3'd5: rd_val = res_ext[63:32];
      3'd6: rd_val = {31'b0, intr_en_q};
      3'd7: rd_val = {31'b0, intr_sts_q};
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    awready_d  = s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~bvalid_q & ~awready_q;
    bvalid_d   = wr_fire | (bvalid_q & ~s_axi.S_AXI_BREADY);
    arready_d  = s_axi.S_AXI_ARVALID & ~rvalid_q & ~arready_q;
    rvalid_d   = rd_fire | (rvalid_q & ~s_axi.S_AXI_RREADY);
    rdata_d    = rd_fire ? rd_val : rdata_q;
    signed_d   = signed_q;
    done_d     = done_q;
    neg_d      = neg_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    mplier_d   = mplier_q;
    res_d      = res_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    intr_en_d  = intr_en_q;
    intr_sts_d = intr_sts_q;
    irq_d      = 1'b0;
    start      = 1'b0;
    opa_wr     = merge(32'(opa_q), s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
    opb_wr     = merge(32'(opb_q), s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
    a_neg      = signed_q & opa_q[OP_W-1];
    b_neg      = signed_q & opb_q[OP_W-1];
    mag_a      = a_neg ? -opa_q : opa_q;
    mag_b      = b_neg ? -opb_q : opb_q;

    // Operand and control writes are silently dropped while an operation is in flight.
    if (wr_fire && !busy) begin
      case (wr_idx)
        3'd0: if (s_axi.S_AXI_WSTRB[0]) begin
          signed_d = s_axi.S_AXI_WDATA[1];
          start    = s_axi.S_AXI_WDATA[0];
        end
        3'd2: opa_d = opa_wr[OP_W-1:0];
        3'd3: opb_d = opb_wr[OP_W-1:0];
        default: ;
      endcase
    end

`ifdef HW_MUL_INTR_EN
    irq_d = intr_sts_q & intr_en_q;
    if (wr_fire && wr_idx == 3'd6 && s_axi.S_AXI_WSTRB[0]) intr_en_d = s_axi.S_AXI_WDATA[0];
    if (wr_fire && wr_idx == 3'd7 && s_axi.S_AXI_WSTRB[0] && s_axi.S_AXI_WDATA[0]) intr_sts_d = 1'b0;
`else
    intr_en_d  = 1'b0;
    intr_sts_d = 1'b0;
`endif

    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        done_d  = 1'b0;
      end
      LOAD: begin
        mcand_d  = PW'(mag_a);
        mplier_d = mag_b;
        neg_d    = a_neg ^ b_neg;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = RUN;
      end
      RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(OP_W - 1)) state_d = FIN;
      end
      FIN: begin
        res_d   = neg_q ? -acc_q : acc_q;
        done_d  = 1'b1;
`ifdef HW_MUL_INTR_EN
        // Placed after the W1C so a clear in the same cycle loses to the set.
        intr_sts_d = 1'b1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= IDLE;
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      signed_q   <= 1'b0;
      done_q     <= 1'b0;
      neg_q      <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      mplier_q   <= '0;
      res_q      <= '0;
      mcand_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      intr_en_q  <= 1'b0;
      intr_sts_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      awready_q  <= awready_d;
      bvalid_q   <= bvalid_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      signed_q   <= signed_d;
      done_q     <= done_d;
      neg_q      <= neg_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      mplier_q   <= mplier_d;
      res_q      <= res_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      intr_en_q  <= intr_en_d;
      intr_sts_q <= intr_sts_d;
      irq_q      <= irq_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_mul_engine.sv
// Self-checking bench for axi_lite_mul_engine: vector table, random vectors vs. arithmetic model,
// and timed sequences for latency, busy writes, interrupt and mid-run reset.
module tb_axi_lite_mul_engine;
  localparam int OP_W  = 32;
  localparam int BOUND = 64;

  localparam logic [4:0] A_CTRL = 5'h00, A_STATUS = 5'h04, A_OPA = 5'h08, A_OPB = 5'h0C;
  localparam logic [4:0] A_RLO = 5'h10, A_RHI = 5'h14, A_IEN = 5'h18, A_ISTS = 5'h1C;

  logic       clk = 1'b0;
  logic       rst;
  logic       irq;
  logic [1:0] dbg_state;
  int         n_vec = 0;
  int         n_err = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;
  vec_t tbl[8];

  axi_lite_mul_engine_if bus();

  axi_lite_mul_engine #(.OP_W(OP_W)) dut (
    .ACLK(clk), .ARESET(rst), .s_axi(bus), .irq(irq), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Driver tasks; each returns #1 after the handshake edge.
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    bus.S_AXI_AWADDR = addr; bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    while (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY) && n < BOUND) begin step(1); n++; end
    check("write_handshake", {31'b0, n < BOUND}, 32'h1);
    if (n < BOUND) begin
      step(1);
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      check("bvalid_bresp", {29'b0, bus.S_AXI_BVALID, bus.S_AXI_BRESP}, 32'h4);
    end else begin
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
    int n = 0;
    data = 32'hDEAD_BEEF;
    bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1;
    while (!bus.S_AXI_ARREADY && n < BOUND) begin step(1); n++; end
    check("read_handshake", {31'b0, n < BOUND}, 32'h1);
    if (n < BOUND) begin
      step(1);
      bus.S_AXI_ARVALID = 1'b0;
      check("rvalid_rresp", {29'b0, bus.S_AXI_RVALID, bus.S_AXI_RRESP}, 32'h4);
      data = bus.S_AXI_RDATA;
    end else begin
      bus.S_AXI_ARVALID = 1'b0;
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    axi_write(A_OPA, a, 4'hF);
    axi_write(A_OPB, b, 4'hF);
    axi_write(A_CTRL, {30'b0, sgn, 1'b1}, 4'hF);
  endtask

  task automatic wait_done();
    logic [31:0] st;
    int n = 0;
    do begin axi_read(A_STATUS, st); n++; end while (st[1] !== 1'b1 && n < BOUND);
    check("done_wait", {31'b0, st[1]}, 32'h1);
  endtask

  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output logic [31:0] hi, output logic [31:0] lo);
    start_op(a, b, sgn);
    wait_done();
    axi_read(A_RLO, lo);
    axi_read(A_RHI, hi);
  endtask

  // Reference model: the exact mathematical product, as plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb;
    if (sgn) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  initial begin
    logic [31:0] d, hi, lo, a, b;
    logic [63:0] p;
    logic        sgn;

    tbl[0] = '{32'h0000FFFF, 32'h00010001, 1'b0, 32'h00000000, 32'hFFFFFFFF};
    tbl[1] = '{32'hFFFFFFFE, 32'h00000003, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA};
    tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
    tbl[3] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000};
    tbl[4] = '{32'h00000000, 32'h12345678, 1'b0, 32'h00000000, 32'h00000000};
    tbl[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001};
    tbl[6] = '{32'h80000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'h80000000};
    tbl[7] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 32'hC0000000, 32'h80000000};

    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b1;
    rst = 1'b1;
    step(2);
    rst = 1'b0;

    // Reset state
    check("rst_handshake_outs", {26'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
                                 bus.S_AXI_ARREADY, bus.S_AXI_RVALID, irq}, 32'h0);
    check("rst_rdata", bus.S_AXI_RDATA, 32'h0);
    for (int i = 0; i < 8; i++) begin
      axi_read(5'(i * 4), d);
      check($sformatf("rst_reg_%0d", i), d, 32'h0);
    end

    // Register access, byte strobes, simultaneous read and write
    axi_write(A_OPA, 32'h12345678, 4'hF);
    axi_read(A_OPA, d);            check("opa_rw", d, 32'h12345678);
    axi_write(A_OPA, 32'hAABBCCDD, 4'b0101);
    axi_read(A_OPA, d);            check("opa_strb", d, 32'h12BB56DD);
    axi_write(A_CTRL, 32'h2, 4'hF);
    axi_read(A_CTRL, d);           check("ctrl_signed", d, 32'h2);
    axi_write(A_CTRL, 32'h0, 4'hF);
    fork
      axi_write(A_OPA, 32'h0000CAFE, 4'hF);
      axi_read(A_OPA, d);
    join
    check("rd_wr_same_cycle_old", d, 32'h12BB56DD);
    axi_read(A_OPA, d);            check("rd_wr_same_cycle_new", d, 32'h0000CAFE);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      do_mul(tbl[i].a, tbl[i].b, tbl[i].sgn, hi, lo);
      check($sformatf("tbl%0d_hi", i), hi, tbl[i].hi);
      check($sformatf("tbl%0d_lo", i), lo, tbl[i].lo);
    end

    // Random vectors against the model
    for (int i = 0; i < 30; i++) begin
      a = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom();
      b = ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF : $urandom();
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000FFFF;
      sgn = 1'($urandom_range(0, 1));
      p = model(a, b, sgn);
      exp_q.push_back(p[31:0]);
      exp_q.push_back(p[63:32]);
      do_mul(a, b, sgn, hi, lo);
      check($sformatf("rnd%0d_lo", i), lo, exp_q.pop_front());
      check($sformatf("rnd%0d_hi", i), hi, exp_q.pop_front());
    end

    // BUSY right after start, DONE exactly OP_W+2 cycles after the START handshake
    start_op(32'h0000FFFF, 32'h00010001, 1'b0);
    axi_read(A_STATUS, d);         check("busy_after_start", d, 32'h1);
    wait_done();
    start_op(32'h0000FFFF, 32'h00010001, 1'b0);
    step(OP_W);
    axi_read(A_STATUS, d);         check("status_at_op_w_plus_1", d, 32'h1);
    wait_done();
    start_op(32'h0000FFFF, 32'h00010001, 1'b0);
    step(OP_W + 1);
    axi_read(A_STATUS, d);         check("status_at_op_w_plus_2", d, 32'h2);
    axi_read(A_RLO, d);            check("t1_lo", d, 32'hFFFFFFFF);
    axi_read(A_RHI, d);            check("t1_hi", d, 32'h00000000);

    // Writes while BUSY are dropped but acknowledged
    start_op(32'h5, 32'h7, 1'b0);
    step(3);
    axi_write(A_OPA, 32'h99, 4'hF);
    axi_write(A_CTRL, 32'h1, 4'hF);
    axi_read(A_RLO, d);            check("res_held_while_busy", d, 32'hFFFFFFFF);
    wait_done();
    axi_read(A_OPA, d);            check("busy_opa_dropped", d, 32'h5);
    axi_read(A_RLO, d);            check("busy_res_lo", d, 32'h23);
    step(OP_W + 8);
    axi_read(A_STATUS, d);         check("single_done", d, 32'h2);

`ifdef HW_MUL_INTR_EN
    axi_write(A_IEN, 32'h1, 4'hF);
    axi_read(A_IEN, d);            check("intr_en_rw", d, 32'h1);
    start_op(32'h2, 32'h3, 1'b0);
    step(OP_W + 2);
    check("irq_with_done", {31'b0, irq}, 32'h0);
    step(1);
    check("irq_after_done", {31'b0, irq}, 32'h1);
    axi_read(A_ISTS, d);           check("intr_sts_set", d, 32'h1);
    axi_read(A_RLO, d);            check("t5_lo", d, 32'h6);
    // W1C landing on the same edge as FIN
    start_op(32'h2, 32'h3, 1'b0);
    step(OP_W);
    axi_write(A_ISTS, 32'h1, 4'hF);
    axi_read(A_ISTS, d);           check("w1c_vs_fin_set_wins", d, 32'h1);
    axi_write(A_ISTS, 32'h1, 4'hF);
    check("irq_at_w1c", {31'b0, irq}, 32'h1);
    step(1);
    check("irq_after_w1c", {31'b0, irq}, 32'h0);
    axi_read(A_ISTS, d);           check("intr_sts_cleared", d, 32'h0);
`else
    axi_write(A_IEN, 32'h1, 4'hF);
    axi_read(A_IEN, d);            check("intr_en_absent", d, 32'h0);
    start_op(32'h2, 32'h3, 1'b0);
    step(OP_W + 3);
    check("irq_tied_low", {31'b0, irq}, 32'h0);
    axi_read(A_ISTS, d);           check("intr_sts_absent", d, 32'h0);
    axi_read(A_RLO, d);            check("t5_lo", d, 32'h6);
`endif

    // Reset in the middle of RUN
    axi_write(A_CTRL, 32'h2, 4'hF);
    start_op(32'h00001234, 32'h00005678, 1'b1);
    step(11);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_mid_irq", {31'b0, irq}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      axi_read(5'(i * 4), d);
      check($sformatf("rst_mid_reg_%0d", i), d, 32'h0);
    end
    do_mul(32'h4, 32'h4, 1'b0, hi, lo);
    check("post_rst_lo", lo, 32'h10);
    check("post_rst_hi", hi, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
